minmax_tracker: RTL



---
 rtl/minmax_tracker_pkg.sv | 14 +
 rtl/minmax_tracker_cmp.sv | 35 +++
 rtl/minmax_tracker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/minmax_tracker_pkg.sv
// Shared definitions for the streaming min/max tracker.
//   CMP_W   : width of the signed comparator (fixed at 8)
//   state_e : tracker FSM state encoding
package minmax_tracker_pkg;

    localparam int CMP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/minmax_tracker_cmp.sv
// Signed 8-bit comparator. Flags are derived from A-B using the
// N^V rule, so the result is correct even when the subtraction
// overflows (e.g. 127 vs -128).
// Ports:
//   a_i  : operand A (two's complement)
//   b_i  : operand B (two's complement)
//   lt_o : A <  B
//   eq_o : A == B
//   gt_o : A >  B
module minmax_tracker_cmp
    import minmax_tracker_pkg::*;
(
    input  logic [CMP_W-1:0] a_i,
    input  logic [CMP_W-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    logic [CMP_W-1:0] diff;
    logic             n_flag;
    logic             v_flag;
    logic             z_flag;

    assign diff   = a_i - b_i;
    assign n_flag = diff[CMP_W-1];
    // Overflow only when operand signs differ and the result sign differs from A.
    assign v_flag = (a_i[CMP_W-1] ^ b_i[CMP_W-1]) & (a_i[CMP_W-1] ^ diff[CMP_W-1]);
    assign z_flag = (diff == '0);

    assign lt_o = n_flag ^ v_flag;
    assign eq_o = z_flag;
    assign gt_o = ~(n_flag ^ v_flag) & ~z_flag;

endmodule

// File: rtl/minmax_tracker.sv
// Streaming min/max tracker. Consumes framed signed samples over a
// valid/ready input and emits one {min, max, count, overflow} result per
// frame over a valid/ready output.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no sample of the current frame accepted yet
// ST_ACCUM | frame in progress, running extremes being updated
// ST_HOLD  | result presented on out_*, input stalled until out_ready
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : sample handshake
//   in_data, in_last    : signed sample, end-of-frame marker
//   out_valid/out_ready : result handshake
//   out_min, out_max    : signed extremes of the last completed frame
//   out_count           : samples in that frame, saturating at 2^CNT_W-1
//   out_overflow        : frame was longer than 2^CNT_W-1 samples
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    if (DATA_W != CMP_W) begin : g_bad_width
        $error("minmax_tracker: DATA_W must be 8 to match the comparator");
    end

    state_e            state_q;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] out_min_q;
    logic [DATA_W-1:0] out_max_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic              out_ovf_q;
    logic              acc;

    logic              min_lt;
    logic              max_gt;
    logic              unused_min_eq;
    logic              unused_min_gt;
    logic              unused_max_lt;
    logic              unused_max_eq;

    minmax_tracker_cmp u_cmp_min (
        .a_i  (in_data),
        .b_i  (min_q),
        .lt_o (min_lt),
        .eq_o (unused_min_eq),
        .gt_o (unused_min_gt)
    );

    minmax_tracker_cmp u_cmp_max (
        .a_i  (in_data),
        .b_i  (max_q),
        .lt_o (unused_max_lt),
        .eq_o (unused_max_eq),
        .gt_o (max_gt)
    );

    assign in_ready = (state_q != ST_HOLD);
    assign acc      = in_valid & in_ready;

    // Candidate accumulator values assuming the current sample is accepted.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == ST_IDLE) begin
            min_d = in_data;
            max_d = in_data;
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
        end else begin
            if (min_lt) min_d = in_data;
            if (max_gt) max_d = in_data;
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output registers are loaded only when a frame completes, so the
    // previous result stays visible while the next frame accumulates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            min_q     <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_min_q <= '0;
            out_max_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (acc) begin
                        min_q <= min_d;
                        max_q <= max_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (in_last) begin
                            state_q   <= ST_HOLD;
                            out_min_q <= min_d;
                            out_max_q <= max_d;
                            out_cnt_q <= cnt_d;
                            out_ovf_q <= ovf_d;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = (state_q == ST_HOLD);
    assign out_min      = out_min_q;
    assign out_max      = out_max_q;
    assign out_count    = out_cnt_q;
    assign out_overflow = out_ovf_q;

endmodule
